// File: rtl/ddr_global_pkg.sv
// ----------------------------------------------------------------------------
// ddr_global_pkg
// Shared types and constants for the DDR FIFO helper blocks.
//   ddr_fifo_loop_state_t : state encoding of ddr_fifo_loop_ctrl
//   DDR_FIFO_LOOP_INF     : loop-count value that means "replay until stopped"
// ----------------------------------------------------------------------------
package ddr_global_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LDPTR = 3'd2,
        FILL  = 3'd3,
        PLAY  = 3'd4,
        DONE  = 3'd5
    } ddr_fifo_loop_state_t;

    localparam logic [31:0] DDR_FIFO_LOOP_INF = '0;

endpackage : ddr_global_pkg

// File: rtl/ddr_fifo_loop_ctrl.sv
// ----------------------------------------------------------------------------
// ddr_fifo_loop_ctrl
// Sequencer that uses a ddr_fifo (SYNC=1) as a looping pattern buffer:
// clear the FIFO, load the window start pointer, fill N entries from an
// upstream source, then replay the window [start_ptr..stop_ptr] for a
// programmed number of loops (0 = until i_stop).
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start / i_stop        sequence start (IDLE only) / abort pulses
//   i_cfg_start_ptr/_stop   replay window, stop inclusive
//   i_cfg_loop_cnt          loops to play, 0 = infinite
//   i_ld_valid, o_ld_ready  fill handshake (o_fifo_write = valid & ready)
//   i_rd_ready              downstream accepts a replay word
//   i_fifo_full             FIFO full flag (used by the error checker only)
//   o_fifo_*                FIFO control pins (everything except data)
//   o_busy, o_done, o_abort status; done/abort are one-cycle pulses
//   o_loop_cnt              completed loops
//   o_err                   sticky error flag
//
// Optional feature: define DDR_FIFO_LOOP_CTRL_ERR_CHK_EN to enable o_err
// (write while FIFO full, or i_start while busy). Otherwise o_err is 0.
// ----------------------------------------------------------------------------
module ddr_fifo_loop_ctrl
    import ddr_global_pkg::*;
#(
    parameter int AWIDTH     = 3,
    parameter int LCNT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [AWIDTH-1:0]     i_cfg_start_ptr,
    input  logic [AWIDTH-1:0]     i_cfg_stop_ptr,
    input  logic [LCNT_WIDTH-1:0] i_cfg_loop_cnt,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic                  i_rd_ready,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_clr,
    output logic                  o_fifo_loop_mode,
    output logic                  o_fifo_load_ptr,
    output logic [AWIDTH-1:0]     o_fifo_start_ptr,
    output logic [AWIDTH-1:0]     o_fifo_stop_ptr,
    output logic                  o_fifo_write,
    output logic                  o_fifo_read,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_abort,
    output logic [LCNT_WIDTH-1:0] o_loop_cnt,
    output logic                  o_err
);

    ddr_fifo_loop_state_t  state_q, state_d;

    logic [AWIDTH-1:0]     start_ptr_q;
    logic [AWIDTH-1:0]     stop_ptr_q;
    logic [LCNT_WIDTH-1:0] cfg_loop_q;

    logic [AWIDTH:0]       ent_cnt_q, ent_cnt_d;
    logic [LCNT_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
    logic                  abort_q, abort_d;

    logic                  start_accept;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [AWIDTH-1:0]     ptr_diff;
    logic [AWIDTH:0]       win_len;
    logic [AWIDTH:0]       ent_inc;
    logic [LCNT_WIDTH-1:0] loop_inc;
    logic                  loop_finite;

    // Window size N = ((stop - start) mod DEPTH) + 1; the AWIDTH-bit
    // subtraction provides the modulo, the extra bit holds N = DEPTH.
    assign ptr_diff    = stop_ptr_q - start_ptr_q;
    assign win_len     = {1'b0, ptr_diff} + (AWIDTH+1)'(1);
    assign ent_inc     = ent_cnt_q + (AWIDTH+1)'(1);
    assign loop_inc    = loop_cnt_q + LCNT_WIDTH'(1);
    assign loop_finite = (cfg_loop_q != LCNT_WIDTH'(DDR_FIFO_LOOP_INF));

    assign start_accept = i_start && (state_q == IDLE);
    assign wr_fire      = i_ld_valid && (state_q == FILL);
    // Reads ignore FIFO empty: in loop mode the pointers coincide once full.
    assign rd_fire      = i_rd_ready && (state_q == PLAY);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ent_cnt_d  = ent_cnt_q;
        loop_cnt_d = loop_cnt_q;
        abort_d    = abort_q;

        if (i_stop && (state_q != IDLE)) begin
            // Abort wins over any same-cycle fill/play progress; counters
            // freeze so o_loop_cnt reports only fully completed loops.
            state_d = CLR;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_d = CLR;
                    end
                end
                CLR: begin
                    ent_cnt_d = '0;
                    abort_d   = 1'b0;
                    if (abort_q) begin
                        // Keep the completed-loop count visible after abort.
                        state_d = IDLE;
                    end else begin
                        loop_cnt_d = '0;
                        state_d    = LDPTR;
                    end
                end
                LDPTR: begin
                    state_d = FILL;
                end
                FILL: begin
                    if (wr_fire) begin
                        if (ent_inc == win_len) begin
                            ent_cnt_d = '0;
                            state_d   = PLAY;
                        end else begin
                            ent_cnt_d = ent_inc;
                        end
                    end
                end
                PLAY: begin
                    if (rd_fire) begin
                        if (ent_inc == win_len) begin
                            ent_cnt_d  = '0;
                            loop_cnt_d = loop_inc;
                            if (loop_finite && (loop_inc == cfg_loop_q)) begin
                                state_d = DONE;
                            end
                        end else begin
                            ent_cnt_d = ent_inc;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            abort_q     <= 1'b0;
            start_ptr_q <= '0;
            stop_ptr_q  <= '0;
            cfg_loop_q  <= '0;
        end else begin
            ent_cnt_q  <= ent_cnt_d;
            loop_cnt_q <= loop_cnt_d;
            abort_q    <= abort_d;
            if (start_accept) begin
                start_ptr_q <= i_cfg_start_ptr;
                stop_ptr_q  <= i_cfg_stop_ptr;
                cfg_loop_q  <= i_cfg_loop_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        o_ld_ready       = 1'b0;
        o_fifo_clr       = 1'b0;
        o_fifo_loop_mode = 1'b0;
        o_fifo_load_ptr  = 1'b0;
        o_fifo_write     = 1'b0;
        o_fifo_read      = 1'b0;
        o_done           = 1'b0;
        o_abort          = 1'b0;
        case (state_q)
            CLR: begin
                o_fifo_clr = 1'b1;
                o_abort    = abort_q;
            end
            LDPTR: begin
                o_fifo_load_ptr  = 1'b1;
                o_fifo_loop_mode = 1'b1;
            end
            FILL: begin
                o_ld_ready       = 1'b1;
                o_fifo_loop_mode = 1'b1;
                o_fifo_write     = wr_fire;
            end
            PLAY: begin
                o_fifo_loop_mode = 1'b1;
                o_fifo_read      = rd_fire;
            end
            DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_busy           = (state_q != IDLE);
    assign o_fifo_start_ptr = start_ptr_q;
    assign o_fifo_stop_ptr  = stop_ptr_q;
    assign o_loop_cnt       = loop_cnt_q;

`ifdef DDR_FIFO_LOOP_CTRL_ERR_CHK_EN
    logic err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (start_accept) begin
            err_q <= 1'b0;
        end else if ((wr_fire && i_fifo_full) || (i_start && (state_q != IDLE))) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    logic unused_fifo_full;
    assign unused_fifo_full = i_fifo_full;
    assign o_err            = 1'b0;
`endif

endmodule : ddr_fifo_loop_ctrl

// File: tb/tb_ddr_fifo_loop_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ddr_fifo_loop_ctrl
// Directed bench for ddr_fifo_loop_ctrl. Expected FIFO control events are
// queued when a sequence is started and popped by a monitor as the DUT
// produces them; status values are checked after each sequence.
// ----------------------------------------------------------------------------
module tb_ddr_fifo_loop_ctrl;

    localparam int AW = 3;
    localparam int LW = 16;

    localparam int EV_CLR   = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_LDPTR = 3;
    localparam int EV_WR    = 4;
    localparam int EV_RD    = 5;
    localparam int EV_DONE  = 6;
    localparam int EV_BAD   = 7;

    typedef struct {
        int code;
        int cyc;   // -1 = any cycle
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [AW-1:0] cfg_start;
    logic [AW-1:0] cfg_stop;
    logic [LW-1:0] cfg_loop;
    logic          ld_valid;
    logic          ld_ready;
    logic          rd_ready;
    logic          fifo_full;
    logic          fifo_clr;
    logic          fifo_loop_mode;
    logic          fifo_load_ptr;
    logic [AW-1:0] fifo_start_ptr;
    logic [AW-1:0] fifo_stop_ptr;
    logic          fifo_write;
    logic          fifo_read;
    logic          busy;
    logic          done;
    logic          abort;
    logic [LW-1:0] loop_cnt;
    logic          err;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    ev_t exp_q[$];

    ddr_fifo_loop_ctrl #(.AWIDTH(AW), .LCNT_WIDTH(LW)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_stop           (stop),
        .i_cfg_start_ptr  (cfg_start),
        .i_cfg_stop_ptr   (cfg_stop),
        .i_cfg_loop_cnt   (cfg_loop),
        .i_ld_valid       (ld_valid),
        .o_ld_ready       (ld_ready),
        .i_rd_ready       (rd_ready),
        .i_fifo_full      (fifo_full),
        .o_fifo_clr       (fifo_clr),
        .o_fifo_loop_mode (fifo_loop_mode),
        .o_fifo_load_ptr  (fifo_load_ptr),
        .o_fifo_start_ptr (fifo_start_ptr),
        .o_fifo_stop_ptr  (fifo_stop_ptr),
        .o_fifo_write     (fifo_write),
        .o_fifo_read      (fifo_read),
        .o_busy           (busy),
        .o_done           (done),
        .o_abort          (abort),
        .o_loop_cnt       (loop_cnt),
        .o_err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int code, input int at);
        ev_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] all_outs();
        return {ld_ready, fifo_clr, fifo_loop_mode, fifo_load_ptr, fifo_start_ptr,
                fifo_stop_ptr, fifo_write, fifo_read, busy, done, abort, loop_cnt, err};
    endfunction

    // Event monitor: each observed FIFO control event must match the head of
    // the expected queue (and its cycle when one was given).
    always @(negedge clk) begin
        if (rst_n) begin
            int code;
            ev_t e;
            code = 0;
            if (abort && !fifo_clr)   code = EV_BAD;
            else if (fifo_clr)        code = abort ? EV_ABORT : EV_CLR;
            else if (fifo_load_ptr)   code = EV_LDPTR;
            else if (fifo_write)      code = EV_WR;
            else if (fifo_read)       code = EV_RD;
            else if (done)            code = EV_DONE;
            if (code != 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", code, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("event", code, e.code);
                    if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
                    $display("event code=%0d cycle=%0d", code, cyc);
                end
            end
        end
    end

    // Pulse i_start with a config; returns the cycle index of the start pulse.
    task automatic start_seq(input int s, input int p, input int l, output int base);
        @(posedge clk); #1;
        cfg_start = AW'(s);
        cfg_stop  = AW'(p);
        cfg_loop  = LW'(l);
        start     = 1'b1;
        base      = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Run until the DUT returns to IDLE with optional per-cycle stimulus.
    task automatic run(input int budget, input bit toggle, input int stop_after,
                       input int stall_after, input int stall_len, input bit restart);
        int reads = 0;
        int stall_left = 0;
        bit stall_done = 0;
        bit stop_done = 0;
        bit in_stall = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            stop  = 1'b0;
            if (toggle) ld_valid = ~ld_valid;
            if (stop_after > 0 && !stop_done && reads == stop_after) begin
                stop      = 1'b1;
                rd_ready  = 1'b0;
                stop_done = 1'b1;
            end
            if (stall_len > 0 && !stall_done && reads == stall_after) begin
                stall_done = 1'b1;
                stall_left = stall_len;
                if (restart) begin
                    start     = 1'b1;
                    cfg_start = 3'd0;
                    cfg_stop  = 3'd7;
                    cfg_loop  = 16'd9;
                end
            end
            if (stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
                in_stall = 1'b1;
            end else begin
                if (stall_done) rd_ready = 1'b1;
                in_stall = 1'b0;
            end
            @(negedge clk);
            if (in_stall) check("stall_no_read", fifo_read, 0);
            if (fifo_read) reads++;
            if (!busy) return;
        end
        check("timeout_busy", busy, 0);
    endtask

    initial begin
        int b;
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_start = '0;
        cfg_stop  = '0;
        cfg_loop  = '0;
        ld_valid  = 1'b0;
        rd_ready  = 1'b0;
        fifo_full = 1'b0;

        #1;
        check("reset_outputs_async", all_outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", all_outs(), 0);

        // 1: window 2..5 (N=4), 3 loops, exact cycle timing
        ld_valid = 1'b1;
        rd_ready = 1'b1;
        start_seq(2, 5, 3, b);
        push(EV_CLR, b + 1);
        push(EV_LDPTR, b + 2);
        for (int k = 0; k < 4; k++)  push(EV_WR, b + 3 + k);
        for (int k = 0; k < 12; k++) push(EV_RD, b + 7 + k);
        push(EV_DONE, b + 19);
        check("t1_busy", busy, 1);
        run(100, 0, 0, 0, 0, 0);
        check("t1_drained", exp_q.size(), 0);
        check("t1_loop_cnt", loop_cnt, 3);
        check("t1_start_ptr", fifo_start_ptr, 2);
        check("t1_stop_ptr", fifo_stop_ptr, 5);
        check("t1_idle", busy, 0);

        // 2: single-entry window 6..6, 2 loops
        start_seq(6, 6, 2, b);
        push(EV_CLR, b + 1);
        push(EV_LDPTR, b + 2);
        push(EV_WR, b + 3);
        push(EV_RD, b + 4);
        push(EV_RD, b + 5);
        push(EV_DONE, b + 6);
        run(100, 0, 0, 0, 0, 0);
        check("t2_drained", exp_q.size(), 0);
        check("t2_loop_cnt", loop_cnt, 2);

        // 3: full-depth window 1..0 (N=8), 1 loop, valid toggling
        ld_valid = 1'b0;
        start_seq(1, 0, 1, b);
        push(EV_CLR, b + 1);
        push(EV_LDPTR, b + 2);
        for (int k = 0; k < 8; k++) push(EV_WR, -1);
        for (int k = 0; k < 8; k++) push(EV_RD, -1);
        push(EV_DONE, -1);
        run(200, 1, 0, 0, 0, 0);
        check("t3_drained", exp_q.size(), 0);
        check("t3_loop_cnt", loop_cnt, 1);

        // 4: infinite loop on window 0..3, stop after 20 reads
        ld_valid = 1'b1;
        rd_ready = 1'b1;
        start_seq(0, 3, 0, b);
        push(EV_CLR, b + 1);
        push(EV_LDPTR, b + 2);
        for (int k = 0; k < 4; k++)  push(EV_WR, -1);
        for (int k = 0; k < 20; k++) push(EV_RD, -1);
        push(EV_ABORT, -1);
        run(200, 0, 20, 0, 0, 0);
        check("t4_drained", exp_q.size(), 0);
        check("t4_loop_cnt", loop_cnt, 5);
        check("t4_idle", busy, 0);

        // 5: window 4..6 (N=3), 2 loops, 5-cycle read stall with busy restart
        rd_ready = 1'b1;
        start_seq(4, 6, 2, b);
        push(EV_CLR, b + 1);
        push(EV_LDPTR, b + 2);
        for (int k = 0; k < 3; k++) push(EV_WR, -1);
        for (int k = 0; k < 6; k++) push(EV_RD, -1);
        push(EV_DONE, -1);
        run(200, 0, 0, 2, 5, 1);
        check("t5_drained", exp_q.size(), 0);
        check("t5_loop_cnt", loop_cnt, 2);
        check("t5_start_ptr", fifo_start_ptr, 4);
        check("t5_stop_ptr", fifo_stop_ptr, 6);
`ifdef DDR_FIFO_LOOP_CTRL_ERR_CHK_EN
        check("t5_err", err, 1);
`else
        check("t5_err", err, 0);
`endif

        // 6: async reset during FILL, then a clean sequence
        ld_valid = 1'b0;
        start_seq(0, 3, 1, b);
        push(EV_CLR, b + 1);
        push(EV_LDPTR, b + 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_in_fill", ld_ready, 1);
        check("t6_err_cleared", err, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_async", all_outs(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("t6_drained", exp_q.size(), 0);
        ld_valid = 1'b1;
        rd_ready = 1'b1;
        start_seq(6, 6, 2, b);
        push(EV_CLR, b + 1);
        push(EV_LDPTR, b + 2);
        push(EV_WR, b + 3);
        push(EV_RD, b + 4);
        push(EV_RD, b + 5);
        push(EV_DONE, b + 6);
        run(100, 0, 0, 0, 0, 0);
        check("t6b_drained", exp_q.size(), 0);
        check("t6b_loop_cnt", loop_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ddr_fifo_loop_ctrl
